sd_req_arbiter: RTL and testbench
=================================

# sd_req_arbiter

Shares the single virtual-disk sector channel of the HPS I/O block between up to four core-side requesters, such as floppy, IDE and DivMMC emulations. It serialises requests round-robin and drives the channel's LBA and per-drive rd/wr strobes. It follows the channel's sd_ack handshake and steers the sector-buffer byte stream to and from the granted requester. It sits between the core's storage emulators and the HPS I/O block, with everything in the clk_sys domain.

## Interface
- NREQ, 4: number of requesters (1–4); requester i maps to drive slot i of the channel.
- WIDE, 0: 1 = 16-bit buffer data; DW = WIDE ? 15 : 7, AW = WIDE ? 7 : 8.
- TIMEOUT, 24'hFFFFFF: clk_sys cycles allowed between strobe assertion and sd_ack rise.

Ports:
- clk_sys  in  1  system clock; all logic single-clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_lba  in  32*NREQ  sector address per requester; slice i = [32i+31:32i].
- req_rd  in  NREQ  level read request; held until req_done/req_err for that requester.
- req_wr  in  NREQ  level write request; same rule.
- req_done  out  NREQ  1-cycle completion pulse.
- req_err  out  NREQ  1-cycle timeout pulse.
- req_buff_wr  out  NREQ  sd_buff_wr gated to the granted requester.
- req_buff_din  in  (DW+1)*NREQ  write-data source per requester.
- busy  out  1  a transaction is in progress.
- grant_idx  out  2  index of the current or last grant.
- sd_lba  out  32  to channel.
- sd_rd  out  NREQ  to channel; at most one bit set.
- sd_wr  out  NREQ  to channel; at most one bit set.
- sd_ack  in  1  from channel.
- sd_buff_wr  in  1  from channel.
- sd_buff_din  out  DW+1  to channel; equals req_buff_din[grant_idx].
- sd_buff_addr and sd_buff_dout are broadcast directly to requesters and do not pass through this block.

## Operation
State machine with four states: IDLE, ISSUE, XFER, DONE.

- **IDLE**
  - Pending set: p[i] = req_rd[i] | req_wr[i].
  - If p != 0 and sd_ack == 0, pick the first set bit searching from (last_grant+1) mod NREQ, wrapping.
  - Latch grant_idx, sd_lba <= req_lba slice, and op (rd if req_rd set, else wr; rd wins when both are set).
  - Go to ISSUE. A stale sd_ack=1 in IDLE blocks granting.
- **ISSUE**
  - Drive sd_rd[g] or sd_wr[g] = 1; the timeout counter counts up.
  - sd_ack == 1: clear the strobe and go to XFER.
  - Counter reaches TIMEOUT-1 without sd_ack: clear the strobe, pulse req_err[g], go to IDLE.
- **XFER**
  - req_buff_wr[g] = sd_buff_wr; sd_buff_din = req_buff_din[g].
  - sd_ack 1->0: go to DONE.
- **DONE**
  - Pulse req_done[g], set last_grant = g, go to IDLE.
- busy = (state != IDLE).
- req_buff_wr is 0 outside XFER.
- In IDLE, sd_buff_din still muxes the last grant_idx.
- Requester deassertion during ISSUE or XFER is ignored; the latched transaction completes.
- Requesters with index >= NREQ do not exist; a 2-bit index never selects beyond NREQ-1.

## Timing
- Reset values: sd_rd = sd_wr = 0, sd_lba = 0, req_done = req_err = 0, grant_idx = 0, last_grant = NREQ-1 (so requester 0 is first), state = IDLE, busy = 0.
- Grant latency is 1 cycle: request seen in IDLE at cycle t, strobe registered high at t+1.
- Strobe falls the cycle after sd_ack is first sampled high.
- req_done is high exactly one cycle, on the cycle after sd_ack is sampled falling.
- The requester must drop its request by the cycle after req_done; IDLE re-samples on that cycle, so a registered drop is never double-served.
- Back-to-back: IDLE → ISSUE minimum is 1 cycle after DONE, which gives 2 idle cycles between transactions.
- Reset mid-transaction clears the strobe immediately and returns to IDLE. Any still-high sd_ack is waited out before the next grant.
- The timeout counter is 24 bits, cleared on entry to ISSUE, and does not wrap.

## Structure
- Package sd_arb_pkg holds:
  - the state enum (IDLE = 0, ISSUE = 1, XFER = 2, DONE = 3);
  - DW/AW derivation functions from WIDE;
  - the TIMEOUT counter width constant.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: pending[NREQ], last[2].
  - Outputs: valid, idx[2].
- The FSM, LBA latch, timeout counter and buffer mux stay in the top level.

## Test plan
- Single read: NREQ=4, req_rd[2]=1, req_lba slice 2 = 0x00001234.
  - sd_rd = 4'b0100 at t+1 with sd_lba = 0x1234.
  - sd_ack pulse high for 600 cycles → strobe clears 1 cycle after ack rises.
  - req_done[2] pulses once, 1 cycle after ack falls.
- Round-robin: req_wr[0], req_rd[1] and req_rd[3] all held from reset.
  - Service order is 0, 1, 3, then 0 again if re-requested.
  - Never two strobe bits set at once.
- Buffer steering: during XFER of requester 1, 512 sd_buff_wr pulses.
  - Only req_buff_wr[1] toggles, with 512 pulses.
  - sd_buff_din tracks req_buff_din slice 1.
- Timeout: TIMEOUT=100, sd_ack held 0.
  - Strobe drops after 100 cycles in ISSUE; req_err[g] pulses once.
  - The next pending requester is granted.
- Stale ack / reset: assert reset_n=0 mid-XFER while sd_ack=1.
  - All outputs return to reset values.
  - After release, no grant until sd_ack=0, then grant proceeds.
- Rd+wr same requester: req_rd[0] = req_wr[0] = 1.
  - sd_rd[0] is issued first.
  - After done, with req_rd dropped, sd_wr[0] is issued.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and width helpers for the HPS sector-channel request arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int TO_W = 24;

    function automatic int dw_of(input int wide);
        return (wide != 0) ? 15 : 7;
    endfunction

    function automatic int aw_of(input int wide);
        return (wide != 0) ? 7 : 8;
    endfunction

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending requester after 'last', wrapping.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] pending,
    input  logic [1:0]      last,
    output logic            valid,
    output logic [1:0]      idx
);

    int w_dist;
    int w_best;

    always_comb begin
        valid  = 1'b0;
        idx    = 2'd0;
        w_best = NREQ;
        w_dist = 0;
        // Distance 0 is the slot right after 'last'; smallest distance wins.
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + 2 * NREQ - 1 - int'(last)) % NREQ;
            if (pending[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = 2'(i);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing the HPS virtual-disk sector channel between up to
// four storage emulators; follows the sd_ack handshake and steers buffer data.
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int              NREQ    = 4,
    parameter int              WIDE    = 0,
    parameter logic [TO_W-1:0] TIMEOUT = 24'hFFFFFF,
    localparam int             DW      = dw_of(WIDE)
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [32*NREQ-1:0]     req_lba,
    input  logic [NREQ-1:0]        req_rd,
    input  logic [NREQ-1:0]        req_wr,
    output logic [NREQ-1:0]        req_done,
    output logic [NREQ-1:0]        req_err,
    output logic [NREQ-1:0]        req_buff_wr,
    input  logic [(DW+1)*NREQ-1:0] req_buff_din,
    output logic                   busy,
    output logic [1:0]             grant_idx,
    output logic [31:0]            sd_lba,
    output logic [NREQ-1:0]        sd_rd,
    output logic [NREQ-1:0]        sd_wr,
    input  logic                   sd_ack,
    input  logic                   sd_buff_wr,
    output logic [DW:0]            sd_buff_din
);

    arb_state_t      r_state;
    logic [1:0]      r_grant;
    logic [1:0]      r_last;
    logic [TO_W-1:0] r_cnt;
    logic [NREQ-1:0] r_sd_rd;
    logic [NREQ-1:0] r_sd_wr;
    logic [NREQ-1:0] r_req_err;
    logic [31:0]     r_sd_lba;

    logic [NREQ-1:0] w_pending;
    logic            w_pick_valid;
    logic [1:0]      w_pick_idx;
    logic [NREQ-1:0] w_pick_sel;
    logic [31:0]     w_pick_lba;
    logic            w_pick_rd;
    logic [NREQ-1:0] w_grant_sel;
    logic [DW:0]     w_buff_din;
    logic            w_can_grant;

    assign w_pending = req_rd | req_wr;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .pending (w_pending),
        .last    (r_last),
        .valid   (w_pick_valid),
        .idx     (w_pick_idx)
    );

    always_comb begin
        w_pick_sel  = '0;
        w_grant_sel = '0;
        w_pick_lba  = '0;
        w_buff_din  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_idx == 2'(i)) begin
                w_pick_sel[i] = 1'b1;
                w_pick_lba    = req_lba[32*i +: 32];
            end
            if (r_grant == 2'(i)) begin
                w_grant_sel[i] = 1'b1;
                w_buff_din     = req_buff_din[(DW+1)*i +: DW+1];
            end
        end
    end

    assign w_pick_rd = |(req_rd & w_pick_sel);

    // A stale ack blocks granting; so does the req_err cycle, because the failed
    // requester only drops its level request one cycle after seeing the pulse.
    assign w_can_grant = w_pick_valid && !sd_ack && (r_req_err == '0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= 2'd0;
            r_last    <= 2'(NREQ - 1);
            r_cnt     <= '0;
            r_sd_rd   <= '0;
            r_sd_wr   <= '0;
            r_req_err <= '0;
            r_sd_lba  <= '0;
        end else begin
            r_req_err <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_can_grant) begin
                        r_grant  <= w_pick_idx;
                        r_sd_lba <= w_pick_lba;
                        r_cnt    <= '0;
                        r_sd_rd  <= w_pick_rd ? w_pick_sel : '0;
                        r_sd_wr  <= w_pick_rd ? '0 : w_pick_sel;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sd_ack) begin
                        r_sd_rd <= '0;
                        r_sd_wr <= '0;
                        r_state <= ST_XFER;
                    end else if (r_cnt == (TIMEOUT - 24'd1)) begin
                        r_sd_rd   <= '0;
                        r_sd_wr   <= '0;
                        r_req_err <= w_grant_sel;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                ST_XFER: begin
                    if (!sd_ack) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_last  <= r_grant;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_done    = (r_state == ST_DONE) ? w_grant_sel : '0;
    assign req_buff_wr = ((r_state == ST_XFER) && sd_buff_wr) ? w_grant_sel : '0;
    assign req_err     = r_req_err;
    assign busy        = (r_state != ST_IDLE);
    assign grant_idx   = r_grant;
    assign sd_lba      = r_sd_lba;
    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign sd_buff_din = w_buff_din;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed and randomized bench for sd_req_arbiter against a queue-free
// behavioural model of the round-robin sector-channel protocol.
module tb_sd_req_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 7;
    localparam int TO   = 100;

    logic                   clk_sys = 1'b0;
    logic                   reset_n = 1'b0;
    logic [32*NREQ-1:0]     req_lba = '0;
    logic [NREQ-1:0]        req_rd = '0;
    logic [NREQ-1:0]        req_wr = '0;
    logic [NREQ-1:0]        req_done;
    logic [NREQ-1:0]        req_err;
    logic [NREQ-1:0]        req_buff_wr;
    logic [(DW+1)*NREQ-1:0] req_buff_din = '0;
    logic                   busy;
    logic [1:0]             grant_idx;
    logic [31:0]            sd_lba;
    logic [NREQ-1:0]        sd_rd;
    logic [NREQ-1:0]        sd_wr;
    logic                   sd_ack = 1'b0;
    logic                   sd_buff_wr = 1'b0;
    logic [DW:0]            sd_buff_din;

    int n_err = 0;
    int n_chk = 0;

    bit          m_rd[NREQ];
    bit          m_wr[NREQ];
    logic [31:0] m_lba[NREQ];
    int          m_last;

    sd_req_arbiter #(.NREQ(NREQ), .WIDE(0), .TIMEOUT(24'd100)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .req_lba      (req_lba),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_done     (req_done),
        .req_err      (req_err),
        .req_buff_wr  (req_buff_wr),
        .req_buff_din (req_buff_din),
        .busy         (busy),
        .grant_idx    (grant_idx),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_rd[i]           = m_rd[i];
            req_wr[i]           = m_wr[i];
            req_lba[32*i +: 32] = m_lba[i];
        end
    endtask

    // Spec rule: first requester with rd|wr pending, scanning from last+1 and wrapping.
    function automatic int exp_pick();
        for (int k = 1; k <= NREQ; k++) begin
            if (m_rd[(m_last + k) % NREQ] || m_wr[(m_last + k) % NREQ])
                return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic add_reqs(input logic [NREQ-1:0] rd, input logic [NREQ-1:0] wr);
        for (int i = 0; i < NREQ; i++) begin
            if (!m_rd[i] && !m_wr[i] && (rd[i] || wr[i]))
                m_lba[i] = $urandom;
            m_rd[i] = m_rd[i] | rd[i];
            m_wr[i] = m_wr[i] | wr[i];
        end
    endtask

    task automatic chk_reset();
        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_sd_lba", sd_lba, 0);
        chk("rst_req_done", req_done, 0);
        chk("rst_req_err", req_err, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_buff_wr", req_buff_wr, 0);
    endtask

    task automatic wait_grant(input int exp_lat, output int g, output logic [NREQ-1:0] oh,
                              output bit is_rd);
        int lat;
        g = exp_pick();
        if (g < 0) g = 0;
        is_rd = m_rd[g];
        oh    = 4'b0001 << g;
        lat   = 0;
        while (((sd_rd | sd_wr) == 0) && (lat < 300)) begin
            step();
            lat++;
        end
        chk("grant_seen", ((sd_rd | sd_wr) != 0), 1);
        if (exp_lat >= 0) chk("grant_latency", lat, exp_lat);
        chk("grant_idx", grant_idx, g);
        chk("sd_rd", sd_rd, is_rd ? oh : 4'b0);
        chk("sd_wr", sd_wr, is_rd ? 4'b0 : oh);
        chk("sd_lba", sd_lba, m_lba[g]);
        chk("busy_issue", busy, 1);
    endtask

    task automatic finish_txn(input int g, input logic [NREQ-1:0] oh, input bit is_rd,
                              input int dly, input int ack_len, input int npulse);
        int cnt_g;
        int cnt_o;
        int cyc;
        cnt_g = 0;
        cnt_o = 0;
        for (int d = 0; d < dly; d++) begin
            sd_buff_wr = (d == 0);
            #1;
            chk("buff_wr_issue", req_buff_wr, 0);
            sd_buff_wr = 1'b0;
            step();
            chk("strobe_hold", sd_rd | sd_wr, oh);
        end
        sd_ack = 1'b1;
        step();
        chk("strobe_clear", sd_rd | sd_wr, 0);
        chk("busy_xfer", busy, 1);
        cyc = 1;
        for (int p = 0; p < npulse; p++) begin
            sd_buff_wr   = 1'b1;
            req_buff_din = $urandom;
            #1;
            if (req_buff_wr[g]) cnt_g++;
            if ((req_buff_wr & ~oh) != 0) cnt_o++;
            chk("buff_din", sd_buff_din, req_buff_din[8*g +: 8]);
            step();
            sd_buff_wr = 1'b0;
            step();
            cyc += 2;
        end
        chk("buff_wr_count", cnt_g, npulse);
        chk("buff_wr_other", cnt_o, 0);
        while (cyc < ack_len) begin
            step();
            cyc++;
        end
        sd_ack = 1'b0;
        step();
        chk("req_done", req_done, oh);
        chk("req_err_on_done", req_err, 0);
        chk("busy_done", busy, 1);
        if (is_rd) m_rd[g] = 1'b0;
        else       m_wr[g] = 1'b0;
        m_last = g;
    endtask

    task automatic post_done();
        drive_reqs();
        step();
        chk("done_clear", req_done, 0);
        chk("busy_idle", busy, 0);
        chk("idle_strobe", sd_rd | sd_wr, 0);
        req_buff_din = $urandom;
        #1;
        chk("idle_din_mux", sd_buff_din, req_buff_din[8*m_last +: 8]);
    endtask

    task automatic full(input int exp_lat, input int dly, input int ack_len, input int npulse,
                        input logic [NREQ-1:0] add_rd, input logic [NREQ-1:0] add_wr,
                        input bit keep_busy);
        int g;
        logic [NREQ-1:0] oh;
        bit is_rd;
        wait_grant(exp_lat, g, oh, is_rd);
        finish_txn(g, oh, is_rd, dly, ack_len, npulse);
        add_reqs(add_rd, add_wr);
        if (keep_busy && (exp_pick() < 0))
            add_reqs(4'b0001 << $urandom_range(0, NREQ - 1), 4'b0);
        post_done();
    endtask

    task automatic to_txn();
        int g;
        int n;
        logic [NREQ-1:0] oh;
        bit is_rd;
        wait_grant(1, g, oh, is_rd);
        n = 0;
        while (((sd_rd | sd_wr) != 0) && (n < 300)) begin
            n++;
            step();
        end
        chk("timeout_len", n, TO);
        chk("req_err", req_err, oh);
        chk("done_on_timeout", req_done, 0);
        chk("busy_after_timeout", busy, 0);
        m_rd[g] = 1'b0;
        m_wr[g] = 1'b0;
        drive_reqs();
        step();
        chk("req_err_clear", req_err, 0);
        chk("no_regrant_on_err", sd_rd | sd_wr, 0);
    endtask

    initial begin
        int g;
        logic [NREQ-1:0] oh;
        bit is_rd;

        // Round-robin: requesters 0 (wr), 1 and 3 (rd) held from reset.
        for (int i = 0; i < NREQ; i++) begin
            m_rd[i]  = 1'b0;
            m_wr[i]  = 1'b0;
            m_lba[i] = $urandom;
        end
        m_wr[0] = 1'b1;
        m_rd[1] = 1'b1;
        m_rd[3] = 1'b1;
        m_last  = NREQ - 1;
        drive_reqs();
        #3;
        chk_reset();
        step();
        step();
        reset_n = 1'b1;
        full(1, 2, 3, 1, 4'b0000, 4'b0000, 1'b0);
        full(1, 2, 3, 1, 4'b0000, 4'b0000, 1'b0);
        full(1, 2, 3, 1, 4'b0000, 4'b0001, 1'b0);
        full(1, 1, 2, 0, 4'b0000, 4'b0000, 1'b0);

        // Single read from requester 2 with a 600-cycle ack.
        m_rd[2]  = 1'b1;
        m_lba[2] = 32'h0000_1234;
        drive_reqs();
        full(1, 3, 600, 0, 4'b0000, 4'b0000, 1'b0);

        // Buffer steering: 512 writes during requester 1's transfer.
        m_rd[1] = 1'b1;
        drive_reqs();
        full(1, 2, 0, 512, 4'b0000, 4'b0000, 1'b0);

        // Read and write both raised on requester 0: read first, then write.
        m_rd[0] = 1'b1;
        m_wr[0] = 1'b1;
        drive_reqs();
        full(1, 1, 4, 2, 4'b0000, 4'b0000, 1'b0);
        full(1, 1, 4, 2, 4'b0000, 4'b0000, 1'b0);

        // Timeout on requester 2, then requester 0 is served.
        m_rd[0]  = 1'b1;
        m_lba[0] = $urandom;
        m_rd[2]  = 1'b1;
        m_lba[2] = $urandom;
        drive_reqs();
        to_txn();
        full(1, 2, 3, 1, 4'b0000, 4'b0000, 1'b0);

        // Reset mid-transfer with sd_ack high; last grant must return to NREQ-1.
        m_rd[0]  = 1'b1;
        m_lba[0] = $urandom;
        m_wr[3]  = 1'b1;
        m_lba[3] = $urandom;
        drive_reqs();
        wait_grant(1, g, oh, is_rd);
        sd_ack = 1'b1;
        step();
        step();
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset();
        m_last = NREQ - 1;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stale_ack_no_grant", sd_rd | sd_wr, 0);
            chk("stale_ack_idle", busy, 0);
        end
        sd_ack = 1'b0;
        full(1, 2, 3, 1, 4'b0000, 4'b0000, 1'b0);
        full(1, 2, 3, 1, 4'b0000, 4'b0000, 1'b0);

        // Randomized traffic.
        add_reqs(4'($urandom) | 4'b0001, 4'($urandom));
        drive_reqs();
        for (int it = 0; it < 30; it++) begin
            full(1, $urandom_range(0, 8), $urandom_range(1, 6), $urandom_range(0, 4),
                 4'($urandom), 4'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
